// File: rtl/sha256_round_ctrl.sv
// Sequences an external single-cycle SHA-256 round datapath through one block:
// it keeps the rolling W window, drives the K ROM index and does the final H + a..h addition.
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int IDX_W      = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     block_in,
  input  logic [255:0]     chain_in,
  output logic [255:0]     dp_state_in,
  input  logic [255:0]     dp_state_out,
  output logic [IDX_W-1:0] round_idx,
  output logic [31:0]      w_out,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     digest
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(NUM_ROUNDS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] t_q;
  logic [31:0]      win_q [16];
  logic [255:0]     chain_q;
  logic [255:0]     digest_q;
  logic             out_valid_q;

  logic [31:0]      w_new_d;
  logic [255:0]     digest_d;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // win_q[0] is W_t; the new tail word is W_(t+16) built from W_(t+14), W_(t+9), W_(t+1), W_t.
  assign w_new_d = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dm_add
      assign digest_d[gi*32 +: 32] = chain_q[gi*32 +: 32] + dp_state_out[gi*32 +: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      chain_q     <= '0;
      digest_q    <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) begin
              win_q[i] <= block_in[511 - 32*i -: 32];
            end
            chain_q <= chain_in;
            t_q     <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          for (int i = 0; i < 15; i++) begin
            win_q[i] <= win_q[i+1];
          end
          win_q[15] <= w_new_d;
          // t_q returns to 0 here so round_idx reads 0 outside ROUND.
          if (t_q == LAST_T) begin
            t_q     <= '0;
            state_q <= FINAL;
          end else begin
            t_q <= t_q + IDX_W'(1);
          end
        end
        FINAL: begin
          digest_q    <= digest_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign round_idx   = t_q;
  assign w_out       = (state_q == ROUND) ? win_q[0] : 32'd0;
  // Round 0 seeds the (unreset) datapath with the chaining value.
  assign dp_state_in = (t_q == '0) ? chain_q : dp_state_out;
  assign out_valid   = out_valid_q;
  assign digest      = digest_q;

endmodule
